// File: rtl/frv_rng_src_pkg.sv
// Shared status codes, op bit indices, LFSR polynomial and FSM state type for the RNG responder.
package frv_rng_src_pkg;

  localparam logic [2:0] RNG_IF_NO_INIT        = 3'b000;
  localparam logic [2:0] RNG_IF_INIT_HEALTHY   = 3'b001;
  localparam logic [2:0] RNG_IF_INIT_UNHEALTHY = 3'b100;

  localparam int RNG_OP_SEED = 0;
  localparam int RNG_OP_SAMP = 1;
  localparam int RNG_OP_TEST = 2;

  // x^32 + x^22 + x^2 + x + 1, Galois form, shifting right
  localparam logic [31:0] RNG_LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } rng_state_t;

  function automatic logic [31:0] rng_lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? RNG_LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/frv_rng_src_if.sv
// CPU RNG request/response channel; the core is the master, the RNG source the slave.
interface frv_rng_src_if;
  logic        rng_req_valid;
  logic [2:0]  rng_req_op;
  logic [31:0] rng_req_data;
  logic        rng_req_ready;
  logic        rng_rsp_valid;
  logic [2:0]  rng_rsp_status;
  logic [31:0] rng_rsp_data;
  logic        rng_rsp_ready;

  modport master (
    output rng_req_valid, rng_req_op, rng_req_data, rng_rsp_ready,
    input  rng_req_ready, rng_rsp_valid, rng_rsp_status, rng_rsp_data
  );

  modport slave (
    input  rng_req_valid, rng_req_op, rng_req_data, rng_rsp_ready,
    output rng_req_ready, rng_rsp_valid, rng_rsp_status, rng_rsp_data
  );
endinterface

// File: rtl/frv_rng_lfsr.sv
// 32-bit Galois LFSR entropy pool: single step, xor-load of seed data, never allowed to hold zero.
module frv_rng_lfsr
  import frv_rng_src_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        step_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] lfsr_nxt_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [31:0] xored;

  always_comb begin
    xored  = lfsr_q ^ load_data_i;
    lfsr_d = lfsr_q;
    if (load_i) begin
      // an all-zero pool would lock up, so fall back to 1
      lfsr_d = (xored == 32'h0) ? 32'h1 : xored;
    end else if (step_i) begin
      lfsr_d = rng_lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) lfsr_q <= RESET_VAL;
    else           lfsr_q <= lfsr_d;
  end

  assign lfsr_nxt_o = rng_lfsr_step(lfsr_q);

endmodule

// File: rtl/frv_rng_src.sv
// Default (non-TRNG) RNG responder: seeded LFSR pool, seed counter and health status.
// Define FRV_RNG_HEALTH_EN to flag back-to-back identical samples as unhealthy.
//   state | meaning
//   IDLE  | ready for a request; seed/test handled here
//   BUSY  | stepping the LFSR for a sample op
//   RESP  | response held until the initiator takes it
module frv_rng_src
  import frv_rng_src_pkg::*;
#(
  parameter int unsigned SEEDS_REQ   = 2,
  parameter int unsigned SAMP_CYCLES = 4,
  parameter logic [31:0] LFSR_RESET  = 32'h0000_0001
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  frv_rng_src_if.slave  rng
);

  localparam int unsigned CW     = (SAMP_CYCLES > 1) ? $clog2(SAMP_CYCLES) : 1;
  localparam logic [3:0]  SEEDS_N = 4'(SEEDS_REQ);

  rng_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  seed_cnt_q, seed_cnt_d;
  logic [2:0]  status_q, status_d;
  logic [2:0]  rsp_status_q, rsp_status_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        lfsr_load, lfsr_step;
  logic [31:0] lfsr_nxt;
  logic        is_seed, is_samp;

`ifdef FRV_RNG_HEALTH_EN
  logic [31:0] last_samp_q, last_samp_d;
  logic        last_vld_q, last_vld_d;
`endif

  // anything that is not exactly seed or samp is answered as test
  assign is_seed = (rng.rng_req_op == 3'b001);
  assign is_samp = (rng.rng_req_op == 3'b010);

  frv_rng_lfsr #(.RESET_VAL(LFSR_RESET)) u_lfsr (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .step_i      (lfsr_step),
    .load_i      (lfsr_load),
    .load_data_i (rng.rng_req_data),
    .lfsr_nxt_o  (lfsr_nxt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    seed_cnt_d   = seed_cnt_q;
    status_d     = status_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
`ifdef FRV_RNG_HEALTH_EN
    last_samp_d  = last_samp_q;
    last_vld_d   = last_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (rng.rng_req_valid) begin
          if (is_seed) begin
            lfsr_load = 1'b1;
            if (seed_cnt_q != SEEDS_N) begin
              seed_cnt_d = seed_cnt_q + 4'd1;
              if (seed_cnt_d == SEEDS_N) status_d = RNG_IF_INIT_HEALTHY;
            end
            rsp_data_d   = 32'h0;
            rsp_status_d = status_d;
            state_d      = RESP;
          end else if (is_samp) begin
            cnt_d   = CW'(SAMP_CYCLES - 1);
            state_d = BUSY;
          end else begin
            rsp_data_d   = 32'h0;
            rsp_status_d = status_q;
            state_d      = RESP;
          end
        end
      end
      BUSY: begin
        lfsr_step = 1'b1;
        if (cnt_q == '0) begin
          state_d      = RESP;
          rsp_status_d = status_q;
          rsp_data_d   = 32'h0;
          if (status_q == RNG_IF_INIT_HEALTHY) begin
            rsp_data_d = lfsr_nxt;
`ifdef FRV_RNG_HEALTH_EN
            if (last_vld_q && (lfsr_nxt == last_samp_q)) begin
              status_d     = RNG_IF_INIT_UNHEALTHY;
              seed_cnt_d   = 4'd0;
              rsp_status_d = RNG_IF_INIT_UNHEALTHY;
              rsp_data_d   = 32'h0;
            end
            last_samp_d = lfsr_nxt;
            last_vld_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rng.rng_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      seed_cnt_q   <= 4'd0;
      status_q     <= RNG_IF_NO_INIT;
      rsp_status_q <= RNG_IF_NO_INIT;
      rsp_data_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seed_cnt_q   <= seed_cnt_d;
      status_q     <= status_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

`ifdef FRV_RNG_HEALTH_EN
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      last_samp_q <= 32'h0;
      last_vld_q  <= 1'b0;
    end else begin
      last_samp_q <= last_samp_d;
      last_vld_q  <= last_vld_d;
    end
  end
`endif

  assign rng.rng_req_ready  = (state_q == IDLE);
  assign rng.rng_rsp_valid  = (state_q == RESP);
  assign rng.rng_rsp_status = rsp_status_q;
  assign rng.rng_rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_frv_rng_src.sv
// Randomized bench for frv_rng_src checked against a transaction-level model of the RNG rules.
module tb_frv_rng_src;
  import frv_rng_src_pkg::*;

  localparam int SEEDS = 2;
  localparam int SAMP  = 4;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;

  frv_rng_src_if rng_if ();

  frv_rng_src #(
    .SEEDS_REQ   (SEEDS),
    .SAMP_CYCLES (SAMP),
    .LFSR_RESET  (32'h0000_0001)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .rng      (rng_if)
  );

  always #5 g_clk = ~g_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] m_lfsr;
  logic [31:0] m_last;
  bit          m_last_vld;
  int          m_cnt;
  logic [2:0]  m_status;

  function automatic logic [31:0] step_n(input logic [31:0] v, input int n);
    logic [31:0] x = v;
    for (int i = 0; i < n; i++)
      x = (x % 2 == 1) ? ((x / 2) ^ POLY) : (x / 2);
    return x;
  endfunction

  // inverse step: the mask's msb is set, so bit31 of the result reveals the shifted-out lsb
  function automatic logic [31:0] unstep_n(input logic [31:0] v, input int n);
    logic [31:0] x = v;
    logic        b;
    for (int i = 0; i < n; i++) begin
      b = x[31];
      x = ((b ? (x ^ POLY) : x) * 2) | {31'h0, b};
    end
    return x;
  endfunction

  task automatic m_reset();
    m_lfsr     = 32'h1;
    m_last     = 32'h0;
    m_last_vld = 1'b0;
    m_cnt      = 0;
    m_status   = 3'b000;
  endtask

  task automatic m_apply(input logic [2:0] op, input logic [31:0] d,
                         output logic [2:0] es, output logic [31:0] ed, output int lat);
    ed  = 32'h0;
    lat = 1;
    case (op)
      3'b001: begin
        m_lfsr = m_lfsr ^ d;
        if (m_lfsr == 32'h0) m_lfsr = 32'h1;
        if (m_cnt < SEEDS) begin
          m_cnt++;
          if (m_cnt == SEEDS) m_status = 3'b001;
        end
      end
      3'b010: begin
        lat    = SAMP + 1;
        m_lfsr = step_n(m_lfsr, SAMP);
        if (m_status == 3'b001) begin
          ed = m_lfsr;
`ifdef FRV_RNG_HEALTH_EN
          if (m_last_vld && m_lfsr == m_last) begin
            m_status = 3'b100;
            m_cnt    = 0;
            ed       = 32'h0;
          end
          m_last     = m_lfsr;
          m_last_vld = 1'b1;
`endif
        end
      end
      default: ;
    endcase
    es = m_status;
  endtask

  // one full request/response; starts and ends on a negedge with the DUT idle
  task automatic txn(input logic [2:0] op, input logic [31:0] d, input int hold);
    logic [2:0]  es;
    logic [31:0] ed;
    int          lat;
    int          n;
    m_apply(op, d, es, ed, lat);
    chk("req_ready_idle", {31'h0, rng_if.rng_req_ready}, 32'h1);
    rng_if.rng_req_valid = 1'b1;
    rng_if.rng_req_op    = op;
    rng_if.rng_req_data  = d;
    @(posedge g_clk);
    @(negedge g_clk);
    rng_if.rng_req_valid = 1'b0;
    rng_if.rng_req_op    = 3'($urandom);
    rng_if.rng_req_data  = $urandom;
    n = 1;
    while (!rng_if.rng_rsp_valid && n < 20) begin
      chk("req_ready_busy", {31'h0, rng_if.rng_req_ready}, 32'h0);
      @(negedge g_clk);
      n++;
    end
    chk("latency", n, lat);
    chk("rsp_valid", {31'h0, rng_if.rng_rsp_valid}, 32'h1);
    if (!rng_if.rng_rsp_valid) return;
    chk("rsp_status", {29'h0, rng_if.rng_rsp_status}, {29'h0, es});
    chk("rsp_data", rng_if.rng_rsp_data, ed);
    for (int i = 0; i < hold; i++) begin
      @(negedge g_clk);
      chk("hold_valid", {31'h0, rng_if.rng_rsp_valid}, 32'h1);
      chk("hold_status", {29'h0, rng_if.rng_rsp_status}, {29'h0, es});
      chk("hold_data", rng_if.rng_rsp_data, ed);
      chk("hold_req_ready", {31'h0, rng_if.rng_req_ready}, 32'h0);
    end
    rng_if.rng_rsp_ready = 1'b1;
    @(negedge g_clk);
    rng_if.rng_rsp_ready = 1'b0;
    chk("rsp_done", {31'h0, rng_if.rng_rsp_valid}, 32'h0);
  endtask

  // start an op, abandon it with reset after `wait_n` cycles
  task automatic rst_mid(input logic [2:0] op, input int wait_n);
    rng_if.rng_req_valid = 1'b1;
    rng_if.rng_req_op    = op;
    rng_if.rng_req_data  = $urandom;
    @(posedge g_clk);
    @(negedge g_clk);
    rng_if.rng_req_valid = 1'b0;
    repeat (wait_n) @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'h0, rng_if.rng_rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, rng_if.rng_req_ready}, 32'h1);
    chk("rst_status", {29'h0, rng_if.rng_rsp_status}, 32'h0);
    m_reset();
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  bad_ops [5];
    logic [2:0]  op;
    logic [31:0] p;
    int          r;
    bad_ops = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    rng_if.rng_req_valid = 1'b0;
    rng_if.rng_req_op    = 3'b000;
    rng_if.rng_req_data  = 32'h0;
    rng_if.rng_rsp_ready = 1'b0;
    m_reset();
    repeat (3) @(negedge g_clk);
    chk("reset_rsp_valid", {31'h0, rng_if.rng_rsp_valid}, 32'h0);
    chk("reset_status", {29'h0, rng_if.rng_rsp_status}, 32'h0);
    chk("reset_data", rng_if.rng_rsp_data, 32'h0);
    chk("reset_req_ready", {31'h0, rng_if.rng_req_ready}, 32'h1);
    g_resetn = 1'b1;
    @(negedge g_clk);

    txn(3'b100, $urandom, 2);
    txn(3'b010, $urandom, 1);
    txn(3'b001, 32'hDEAD_BEEF, 0);
    txn(3'b001, 32'h1234_5678, 0);
    txn(3'b100, $urandom, 0);
    // pool xored with itself -> zero guard reloads 1
    txn(3'b001, m_lfsr, 0);
    chk("zero_guard_model", m_lfsr, 32'h1);
    txn(3'b010, $urandom, 0);
    txn(3'b100, $urandom, 10);

    // steer the pool so the next sample repeats the previous one
    p = unstep_n(m_lfsr, SAMP);
    txn(3'b001, m_lfsr ^ p, 0);
    txn(3'b010, $urandom, 0);
    txn(3'b001, $urandom, 0);
    txn(3'b001, $urandom, 0);
    txn(3'b100, $urandom, 0);
    txn(3'b010, $urandom, 0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      op = 3'b001;
      else if (r <= 6) op = 3'b010;
      else if (r <= 8) op = 3'b100;
      else             op = bad_ops[$urandom_range(0, 4)];
      txn(op, $urandom, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge g_clk);
    end

    rst_mid(3'b010, 2);
    txn(3'b100, $urandom, 0);
    txn(3'b001, $urandom, 0);
    rst_mid(3'b100, 3);
    txn(3'b010, $urandom, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
